// File: rtl/stage5_defast_serializer.sv
// Stage 5 of the FAST decoder: compacts up to three decoded messages per beat into a FIFO,
// drains it one message per cycle and maintains the copy-operator dictionary for stage 4.
module stage5_defast_serializer #(
  parameter int unsigned           MSG_BITS    = 280,
  parameter int unsigned           DEPTH       = 8,
  parameter logic [MSG_BITS-1:0]   DEFAULT_MSG = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MSG_BITS-1:0] message_1,
  input  logic [MSG_BITS-1:0] message_2,
  input  logic [MSG_BITS-1:0] message_3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MSG_BITS-1:0] out_message,
  output logic [7:0]          field_PID1,
  output logic [7:0]          field_MC1,
  output logic [7:0]          field_MT1,
  output logic [15:0]         msg_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [MSG_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [15:0]         r_msg_count;
  logic [7:0]          r_pid1;
  logic [7:0]          r_mc1;
  logic [7:0]          r_mt1;

  logic [2:0]          w_nonempty;
  logic [1:0]          w_n;
  logic [1:0]          w_push_n;
  logic                w_accept;
  logic                w_pop;
  logic [AW-1:0]       w_addr_2;
  logic [AW-1:0]       w_addr_3;
  logic [MSG_BITS-1:0] w_last_msg;

  // Ready looks only at the registered occupancy, so a pop in the same cycle earns no credit.
  assign in_ready    = (r_count <= CNT_W'(DEPTH - 3));
  assign out_valid   = (r_count != '0);
  assign out_message = r_mem[r_rd_ptr];
  assign field_PID1  = r_pid1;
  assign field_MC1   = r_mc1;
  assign field_MT1   = r_mt1;
  assign msg_count   = r_msg_count;

  assign w_accept = in_valid && in_ready && rst_n;
  assign w_pop    = out_valid && out_ready;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_nonempty = '0;
    w_last_msg = message_1;
    w_nonempty[0] = (message_1 != DEFAULT_MSG);
    w_nonempty[1] = (message_2 != DEFAULT_MSG);
    w_nonempty[2] = (message_3 != DEFAULT_MSG);
    w_n = {1'b0, w_nonempty[0]} + {1'b0, w_nonempty[1]} + {1'b0, w_nonempty[2]};
    w_push_n = w_accept ? w_n : 2'd0;
    // Later slots land after however many earlier slots were non-empty; the AW-bit sum wraps at DEPTH.
    w_addr_2 = r_wr_ptr + AW'(w_nonempty[0]);
    w_addr_3 = w_addr_2 + AW'(w_nonempty[1]);
    if (w_nonempty[2]) begin
      w_last_msg = message_3;
    end else if (w_nonempty[1]) begin
      w_last_msg = message_2;
    end
  end

  // NOTE: storage has no reset; out_message is only meaningful once count says a slot is filled.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (w_nonempty[0]) r_mem[r_wr_ptr] <= message_1;
      if (w_nonempty[1]) r_mem[w_addr_2] <= message_2;
      if (w_nonempty[2]) r_mem[w_addr_3] <= message_3;
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_msg_count <= '0;
      r_pid1      <= '0;
      r_mc1       <= '0;
      r_mt1       <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_push_n);
      r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
      r_count     <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop);
      r_msg_count <= r_msg_count + 16'(w_push_n);
      if (w_push_n != 2'd0) begin
        r_pid1 <= w_last_msg[MSG_BITS-1  -: 8];
        r_mc1  <= w_last_msg[MSG_BITS-9  -: 8];
        r_mt1  <= w_last_msg[MSG_BITS-17 -: 8];
      end
    end
  end

endmodule
